// File: rtl/ioctl_upload_reader.sv
// ioctl upload read path: serves HPS reads from core RAM, tracks game writes.
// Optional UPLOAD_CHECKSUM_EN: read at 2**AW returns session byte sum.
module ioctl_upload_reader #(
    parameter int          AW     = 12,
    parameter int          RD_LAT = 2,
    parameter logic [23:0] QUIET  = 24'd1_000_000,
    parameter logic [7:0]  INDEX  = 8'd4
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          ioctl_upload,
    input  logic [7:0]    ioctl_index,
    input  logic          ioctl_rd,
    input  logic [24:0]   ioctl_addr,
    output logic [7:0]    ioctl_din,
    output logic          ioctl_upload_req,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd,
    input  logic [7:0]    mem_q,
    input  logic          mem_wr_mon,
    output logic          pause_req,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OPEN  = 2'd1,
        FETCH = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam logic [24:0] RAM_BYTES = 25'(1) << AW;
    localparam logic [2:0]  LAT_LAST  = 3'(RD_LAT - 1);

    state_t      state, state_n;
    logic        sess_r;
    logic [2:0]  lat_cnt;
    logic        cur_ram;
    logic        cur_sum;
    logic        pend_v;
    logic [24:0] pend_addr;
    logic        dirty;
    logic        wr_sess;
    logic [23:0] qcnt;

    logic        launch;
    logic        done;
    logic [24:0] l_addr;
    logic        l_in_ram;
    logic        sess_end;
    logic        req;
    logic [7:0]  fetch_byte;

`ifdef UPLOAD_CHECKSUM_EN
    logic [7:0]  csum;
`endif

    assign sess_end  = (state != IDLE) && !sess_r;
    assign l_in_ram  = l_addr < RAM_BYTES;
    assign pause_req = state != IDLE;
    assign busy      = state == FETCH;

    // Quiet window elapsed with no write this cycle: hand off to HPS.
    assign req = dirty && (qcnt == QUIET) && (state == IDLE) && !mem_wr_mon;
    assign ioctl_upload_req = req;

    always_comb begin
        state_n = state;
        launch  = 1'b0;
        done    = 1'b0;
        l_addr  = ioctl_addr;
        if (sess_end) begin
            state_n = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (sess_r) state_n = OPEN;
                end
                OPEN: begin
                    if (ioctl_rd) begin
                        launch  = 1'b1;
                        state_n = FETCH;
                    end
                end
                FETCH: begin
                    if (lat_cnt == LAT_LAST) begin
                        done    = 1'b1;
                        state_n = HOLD;
                    end
                end
                HOLD: begin
                    if (ioctl_rd) begin
                        launch  = 1'b1;
                        state_n = FETCH;
                    end else if (pend_v) begin
                        launch  = 1'b1;
                        l_addr  = pend_addr;
                        state_n = FETCH;
                    end else begin
                        state_n = OPEN;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_comb begin
        fetch_byte = cur_ram ? mem_q : 8'hFF;
`ifdef UPLOAD_CHECKSUM_EN
        if (cur_sum) fetch_byte = csum;
`endif
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            sess_r    <= 1'b0;
            lat_cnt   <= 3'd0;
            cur_ram   <= 1'b0;
            cur_sum   <= 1'b0;
            pend_v    <= 1'b0;
            pend_addr <= 25'd0;
            ioctl_din <= 8'h00;
            mem_addr  <= '0;
            mem_rd    <= 1'b0;
        end else begin
            state  <= state_n;
            sess_r <= ioctl_upload && (ioctl_index == INDEX);
            mem_rd <= 1'b0;
            if (state == FETCH) lat_cnt <= lat_cnt + 3'd1;
            if (launch) begin
                lat_cnt <= 3'd0;
                cur_ram <= l_in_ram;
                cur_sum <= l_addr == RAM_BYTES;
                pend_v  <= 1'b0;
                if (l_in_ram) begin
                    mem_addr <= l_addr[AW-1:0];
                    mem_rd   <= 1'b1;
                end
            end
            if (state == FETCH && sess_r && ioctl_rd) begin
                pend_v    <= 1'b1;
                pend_addr <= ioctl_addr;
            end
            if (done) ioctl_din <= fetch_byte;
            if (sess_end) pend_v <= 1'b0;
        end
    end

`ifdef UPLOAD_CHECKSUM_EN
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            csum <= 8'h00;
        end else if (state == IDLE && sess_r) begin
            csum <= 8'h00;
        end else if (done && !cur_sum) begin
            csum <= csum + fetch_byte;
        end
    end
`endif

    // Session-time writes survive the hand-over clear and re-arm dirty.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            dirty   <= 1'b0;
            wr_sess <= 1'b0;
            qcnt    <= 24'd0;
        end else begin
            if (mem_wr_mon) qcnt <= 24'd0;
            else if (qcnt != QUIET) qcnt <= qcnt + 24'd1;
            if (sess_end) begin
                dirty   <= wr_sess || mem_wr_mon;
                wr_sess <= 1'b0;
            end else begin
                if (req) dirty <= 1'b0;
                else if (mem_wr_mon) dirty <= 1'b1;
                if (state != IDLE && mem_wr_mon) wr_sess <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ioctl_upload_reader.sv
// Bench for ioctl_upload_reader: scoreboarded reads, quiet-timer and reset checks.
// Models a RAM whose data is valid on the second cycle of a read.
module tb_ioctl_upload_reader;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        ioctl_upload = 1'b0;
    logic [7:0]  ioctl_index = 8'd0;
    logic        ioctl_rd = 1'b0;
    logic [24:0] ioctl_addr = 25'd0;
    logic [7:0]  ioctl_din;
    logic        ioctl_upload_req;
    logic [11:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_q = 8'h00;
    logic        mem_wr_mon = 1'b0;
    logic        pause_req;
    logic        busy;

    ioctl_upload_reader #(.QUIET(24'd16)) dut (
        .clk_sys          (clk_sys),
        .reset_n          (reset_n),
        .ioctl_upload     (ioctl_upload),
        .ioctl_index      (ioctl_index),
        .ioctl_rd         (ioctl_rd),
        .ioctl_addr       (ioctl_addr),
        .ioctl_din        (ioctl_din),
        .ioctl_upload_req (ioctl_upload_req),
        .mem_addr         (mem_addr),
        .mem_rd           (mem_rd),
        .mem_q            (mem_q),
        .mem_wr_mon       (mem_wr_mon),
        .pause_req        (pause_req),
        .busy             (busy)
    );

    always #5 clk_sys = ~clk_sys;

    logic [7:0] ram [4096];
    always @(posedge clk_sys) if (mem_rd) mem_q <= ram[mem_addr];

    int total = 0;
    int bad = 0;
    int n_memrd = 0;
    logic busy_q = 1'b0;
    logic [7:0] exp_q [$];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk_sys) begin
        if (!reset_n) begin
            busy_q = 1'b0;
        end else begin
            if (mem_rd) n_memrd++;
            if (busy_q && !busy) begin
                if (exp_q.size() == 0) chk("sb_extra", 32'(ioctl_din), 32'hFFFF);
                else chk("sb_din", 32'(ioctl_din), 32'(exp_q.pop_front()));
            end
            busy_q = busy;
        end
    end

    // Caller is aligned just after a posedge.
    task automatic rd(input logic [24:0] a);
        ioctl_rd = 1'b1;
        ioctl_addr = a;
        @(posedge clk_sys); #1;
        ioctl_rd = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic drain;
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 60) begin
            tick(1);
            k++;
        end
        chk("drain", exp_q.size(), 0);
        tick(2);
    endtask

    task automatic open_sess(input logic [7:0] idx);
        ioctl_index = idx;
        ioctl_upload = 1'b1;
        tick(3);
    endtask

    task automatic close_sess;
        ioctl_upload = 1'b0;
        tick(3);
    endtask

    task automatic wr_pulse;
        mem_wr_mon = 1'b1;
        tick(1);
        mem_wr_mon = 1'b0;
    endtask

    // Counts upload_req pulses over a window; cycle 1 is right after the write.
    task automatic watch_req(input int n, output int first, output int cnt);
        first = -1;
        cnt = 0;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk_sys);
            if (ioctl_upload_req) begin
                cnt++;
                if (first < 0) first = k;
            end
        end
        #6;
    endtask

    initial begin
        int m0, first, cnt;
        for (int i = 0; i < 4096; i++) ram[i] = 8'(i) ^ 8'h5A;
        ram[5] = 8'h3C;
        ram[6] = 8'hA7;
        ram[16] = 8'h01;
        ram[17] = 8'h02;
        ram[18] = 8'hFF;

        #12;
        chk("rst_din", 32'(ioctl_din), 0);
        chk("rst_req", 32'(ioctl_upload_req), 0);
        chk("rst_memrd", 32'(mem_rd), 0);
        chk("rst_pause", 32'(pause_req), 0);
        chk("rst_busy", 32'(busy), 0);
        reset_n = 1'b1;
        tick(2);

        open_sess(8'd3);
        chk("wrong_idx_pause", 32'(pause_req), 0);
        close_sess();

        open_sess(8'd4);
        chk("open_pause", 32'(pause_req), 1);

        exp_q.push_back(8'h3C);
        rd(25'd5);
        @(negedge clk_sys);
        chk("lat_memrd1", 32'(mem_rd), 1);
        chk("lat_addr", 32'(mem_addr), 5);
        chk("lat_busy1", 32'(busy), 1);
        @(negedge clk_sys);
        chk("lat_memrd2", 32'(mem_rd), 0);
        chk("lat_busy2", 32'(busy), 1);
        @(negedge clk_sys);
        chk("lat_busy3", 32'(busy), 0);
        chk("lat_din3", 32'(ioctl_din), 32'h3C);
        #6;
        drain();

        exp_q.push_back(8'h3C);
        exp_q.push_back(8'hA7);
        rd(25'd5);
        rd(25'd6);
        drain();

        m0 = n_memrd;
        exp_q.push_back(ram[32]);
        exp_q.push_back(ram[34]);
        rd(25'd32);
        rd(25'd33);
        rd(25'd34);
        drain();
        chk("pend_memrd_n", n_memrd - m0, 2);

        m0 = n_memrd;
        exp_q.push_back(8'hFF);
        rd(25'h1000);
        drain();
        exp_q.push_back(8'hFF);
        rd(25'h1FF_FFFF);
        drain();
        chk("oor_no_memrd", n_memrd - m0, 0);
        close_sess();
        chk("closed_pause", 32'(pause_req), 0);
        chk("closed_din", 32'(ioctl_din), 32'hFF);

        open_sess(8'd4);
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h02);
        exp_q.push_back(8'hFF);
`ifdef UPLOAD_CHECKSUM_EN
        exp_q.push_back(8'h02);
`else
        exp_q.push_back(8'hFF);
`endif
        rd(25'd16);
        tick(4);
        rd(25'd17);
        tick(4);
        rd(25'd18);
        tick(4);
        rd(25'h1000);
        drain();
        close_sess();

        wr_pulse();
        watch_req(40, first, cnt);
        chk("quiet_first", first, 17);
        chk("quiet_count", cnt, 1);

        wr_pulse();
        tick(5);
        open_sess(8'd4);
        close_sess();
        watch_req(30, first, cnt);
        chk("handover_clear", cnt, 0);

        open_sess(8'd4);
        wr_pulse();
        tick(1);
        ioctl_upload = 1'b0;
        #1;
        watch_req(40, first, cnt);
        chk("sess_wr_first", first, 16);
        chk("sess_wr_count", cnt, 1);

        open_sess(8'd4);
        rd(25'd5);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 0);
        chk("arst_memrd", 32'(mem_rd), 0);
        chk("arst_din", 32'(ioctl_din), 0);
        chk("arst_pause", 32'(pause_req), 0);
        tick(2);
        reset_n = 1'b1;
        m0 = n_memrd;
        tick(8);
        chk("arst_no_memrd", n_memrd - m0, 0);
        chk("arst_reopen", 32'(pause_req), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
